// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the 4-bit-address bus CPU: T-state counter plus opcode/flag strobe decode.
// Latency: strobes are combinational from the current step; step/halt state updates on the rising clock edge.
// Backpressure: run=0 freezes the step counter and zeroes all strobes; optional CTRL_EARLY_FETCH_EN ends instructions at their last active step.
module control_sequencer #(
    parameter int T_MAX    = 5,
    parameter int OPCODE_W = 4
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic [2:0]          t_state,
    output logic                pc_out,
    output logic                pc_inc,
    output logic                jmp,
    output logic                mar_in,
    output logic                ram_in,
    output logic                ram_out,
    output logic                ir_in,
    output logic                ir_out,
    output logic                a_in,
    output logic                a_out,
    output logic                b_in,
    output logic                alu_out,
    output logic                sub,
    output logic                flags_in,
    output logic                out_in,
    output logic                halted
);

    localparam logic [2:0] T_LAST = 3'(T_MAX);

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

    logic [2:0] t, t_nxt;
    logic       halted_r, halted_nxt;
    logic       instr_done;
    logic       active;

`ifdef CTRL_EARLY_FETCH_EN
    logic [2:0] last_step;

    // HLT keeps the full-length step sequence; it freezes on its own anyway.
    always_comb begin
        last_step = 3'd2;
        case (opcode)
            OP_LDA, OP_STA: last_step = 3'd3;
            OP_ADD, OP_SUB: last_step = 3'd4;
            OP_HLT:         last_step = T_LAST;
            default:        last_step = 3'd2;
        endcase
    end

    assign instr_done = (t == last_step);
`else
    assign instr_done = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            t        <= 3'd0;
            halted_r <= 1'b0;
        end else begin
            t        <= t_nxt;
            halted_r <= halted_nxt;
        end
    end

    always_comb begin
        t_nxt      = t;
        halted_nxt = halted_r;
        if (run && !halted_r) begin
            t_nxt = (t == T_LAST || instr_done) ? 3'd0 : t + 3'd1;
            if (t == 3'd2 && opcode == OP_HLT)
                halted_nxt = 1'b1;
        end
    end

    assign active  = run && !halted_r && !clear;
    assign t_state = clear ? 3'd0 : t;
    assign halted  = halted_r && !clear;

    always_comb begin
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        jmp      = 1'b0;
        mar_in   = 1'b0;
        ram_in   = 1'b0;
        ram_out  = 1'b0;
        ir_in    = 1'b0;
        ir_out   = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        sub      = 1'b0;
        flags_in = 1'b0;
        out_in   = 1'b0;
        if (active) begin
            case (t)
                3'd0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                end
                3'd1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_inc  = 1'b1;
                end
                3'd2: begin
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out = 1'b1;
                            jmp    = 1'b1;
                        end
                        OP_JC: begin
                            ir_out = carry_flag;
                            jmp    = carry_flag;
                        end
                        OP_JZ: begin
                            ir_out = zero_flag;
                            jmp    = zero_flag;
                        end
                        OP_OUT: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd3: begin
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                3'd4: begin
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out  = 1'b1;
                        a_in     = 1'b1;
                        flags_in = 1'b1;
                        sub      = (opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: instruction table plus run-stall, halt and reset sequences.
module tb_control_sequencer;

    localparam logic [14:0] S_PC_OUT   = 15'h4000;
    localparam logic [14:0] S_PC_INC   = 15'h2000;
    localparam logic [14:0] S_JMP      = 15'h1000;
    localparam logic [14:0] S_MAR_IN   = 15'h0800;
    localparam logic [14:0] S_RAM_IN   = 15'h0400;
    localparam logic [14:0] S_RAM_OUT  = 15'h0200;
    localparam logic [14:0] S_IR_IN    = 15'h0100;
    localparam logic [14:0] S_IR_OUT   = 15'h0080;
    localparam logic [14:0] S_A_IN     = 15'h0040;
    localparam logic [14:0] S_A_OUT    = 15'h0020;
    localparam logic [14:0] S_B_IN     = 15'h0010;
    localparam logic [14:0] S_ALU_OUT  = 15'h0008;
    localparam logic [14:0] S_SUB      = 15'h0004;
    localparam logic [14:0] S_FLAGS_IN = 15'h0002;
    localparam logic [14:0] S_OUT_IN   = 15'h0001;
    localparam logic [14:0] F0 = S_PC_OUT | S_MAR_IN;
    localparam logic [14:0] F1 = S_RAM_OUT | S_IR_IN | S_PC_INC;

    logic       clock = 1'b0;
    logic       clear, run, carry_flag, zero_flag;
    logic [3:0] opcode;
    logic [2:0] t_state;
    logic pc_out, pc_inc, jmp, mar_in, ram_in, ram_out, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_out, sub, flags_in, out_in, halted;
    logic [14:0] act;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      name;
        logic [2:0] t;
        logic [14:0] s;
        logic       h;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        c;
        logic        z;
        logic [14:0] e2;
        logic [14:0] e3;
        logic [14:0] e4;
        int          len_early;
    } vec_t;
    vec_t vt[13];

    control_sequencer #(.T_MAX(5), .OPCODE_W(4)) dut (
        .clock(clock), .clear(clear), .run(run), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag), .t_state(t_state),
        .pc_out(pc_out), .pc_inc(pc_inc), .jmp(jmp), .mar_in(mar_in),
        .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out),
        .sub(sub), .flags_in(flags_in), .out_in(out_in), .halted(halted)
    );

    assign act = {pc_out, pc_inc, jmp, mar_in, ram_in, ram_out, ir_in, ir_out,
                  a_in, a_out, b_in, alu_out, sub, flags_in, out_in};

    always #5 clock = ~clock;

    // Inputs are already driven; queue the expectation, compare at the falling edge, return just after the next rising edge.
    task automatic step(input string nm, input logic [2:0] et, input logic [14:0] es, input logic eh);
        exp_t e;
        e.name = nm; e.t = et; e.s = es; e.h = eh;
        sb.push_back(e);
        @(negedge clock);
        e = sb.pop_front();
        n_tests++;
        if (t_state !== e.t || act !== e.s || halted !== e.h) begin
            n_fail++;
            $display("FAIL %s: got t_state=%0d strobes=%h halted=%b, expected t_state=%0d strobes=%h halted=%b",
                     e.name, t_state, act, halted, e.t, e.s, e.h);
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [14:0] exp_at(input vec_t v, input int k);
        case (k)
            0: return F0;
            1: return F1;
            2: return v.e2;
            3: return v.e3;
            4: return v.e4;
            default: return 15'h0;
        endcase
    endfunction

    initial begin
        vt[0]  = '{"NOP",   4'b0000, 1'b0, 1'b0, 15'h0, 15'h0, 15'h0, 3};
        vt[1]  = '{"LDA",   4'b0001, 1'b0, 1'b0, S_IR_OUT | S_MAR_IN, S_RAM_OUT | S_A_IN, 15'h0, 4};
        vt[2]  = '{"ADD",   4'b0010, 1'b1, 1'b1, S_IR_OUT | S_MAR_IN, S_RAM_OUT | S_B_IN,
                   S_ALU_OUT | S_A_IN | S_FLAGS_IN, 5};
        vt[3]  = '{"SUB",   4'b0011, 1'b0, 1'b0, S_IR_OUT | S_MAR_IN, S_RAM_OUT | S_B_IN,
                   S_ALU_OUT | S_A_IN | S_FLAGS_IN | S_SUB, 5};
        vt[4]  = '{"STA",   4'b0100, 1'b0, 1'b0, S_IR_OUT | S_MAR_IN, S_A_OUT | S_RAM_IN, 15'h0, 4};
        vt[5]  = '{"LDI",   4'b0101, 1'b0, 1'b0, S_IR_OUT | S_A_IN, 15'h0, 15'h0, 3};
        vt[6]  = '{"JMP",   4'b0110, 1'b0, 1'b0, S_IR_OUT | S_JMP, 15'h0, 15'h0, 3};
        vt[7]  = '{"JC_t",  4'b0111, 1'b1, 1'b0, S_IR_OUT | S_JMP, 15'h0, 15'h0, 3};
        vt[8]  = '{"JC_nt", 4'b0111, 1'b0, 1'b1, 15'h0, 15'h0, 15'h0, 3};
        vt[9]  = '{"JZ_t",  4'b1000, 1'b0, 1'b1, S_IR_OUT | S_JMP, 15'h0, 15'h0, 3};
        vt[10] = '{"JZ_nt", 4'b1000, 1'b1, 1'b0, 15'h0, 15'h0, 15'h0, 3};
        vt[11] = '{"OUT",   4'b1110, 1'b0, 1'b0, S_A_OUT | S_OUT_IN, 15'h0, 15'h0, 3};
        vt[12] = '{"UNDEF", 4'b1010, 1'b1, 1'b1, 15'h0, 15'h0, 15'h0, 3};

        clear = 1'b1; run = 1'b1; opcode = 4'b0001; carry_flag = 1'b0; zero_flag = 1'b0;
        @(posedge clock);
        #1;
        step("reset_c0", 3'd0, 15'h0, 1'b0);
        step("reset_c1", 3'd0, 15'h0, 1'b0);
        clear = 1'b0;

        foreach (vt[i]) begin
            int len;
`ifdef CTRL_EARLY_FETCH_EN
            len = vt[i].len_early;
`else
            len = 6;
`endif
            opcode = vt[i].op; carry_flag = vt[i].c; zero_flag = vt[i].z;
            for (int k = 0; k < len; k++)
                step($sformatf("%s_T%0d", vt[i].name, k), 3'(k), exp_at(vt[i], k), 1'b0);
        end

        // ADD stalled at T3 by run=0, then resumed at the same step.
        opcode = 4'b0010; carry_flag = 1'b0; zero_flag = 1'b0;
        step("stall_T0", 3'd0, F0, 1'b0);
        step("stall_T1", 3'd1, F1, 1'b0);
        step("stall_T2", 3'd2, S_IR_OUT | S_MAR_IN, 1'b0);
        run = 1'b0;
        for (int k = 0; k < 3; k++)
            step($sformatf("stall_hold%0d", k), 3'd3, 15'h0, 1'b0);
        run = 1'b1;
        step("stall_T3", 3'd3, S_RAM_OUT | S_B_IN, 1'b0);
        step("stall_T4", 3'd4, S_ALU_OUT | S_A_IN | S_FLAGS_IN, 1'b0);
`ifndef CTRL_EARLY_FETCH_EN
        step("stall_T5", 3'd5, 15'h0, 1'b0);
`endif

        // HLT: sticky halt with a frozen step counter until clear.
        opcode = 4'b1111;
        step("hlt_T0", 3'd0, F0, 1'b0);
        step("hlt_T1", 3'd1, F1, 1'b0);
        step("hlt_T2", 3'd2, 15'h0, 1'b0);
        opcode = 4'b0001;
        for (int k = 0; k < 12; k++)
            step($sformatf("hlt_hold%0d", k), 3'd3, 15'h0, 1'b1);
        clear = 1'b1;
        step("hlt_clear", 3'd0, 15'h0, 1'b0);
        clear = 1'b0;
        step("post_clear_T0", 3'd0, F0, 1'b0);
        step("post_clear_T1", 3'd1, F1, 1'b0);

        // Clear and HLT at T2 together: clear wins, no halt.
        opcode = 4'b1111;
        clear = 1'b1;
        step("clr_hlt_T2", 3'd0, 15'h0, 1'b0);
        clear = 1'b0;
        step("clr_hlt_after", 3'd0, F0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 4-bit-address bus CPU; sequences the program counter, MAR, RAM, instruction register, A/B registers, ALU and output register.
- Holds a T-state step counter.
- Decodes the IR opcode nibble plus the carry and zero flags into one-hot-free control strobes per clock.
- Drives pc_out, pc_inc and jmp of the program counter directly, so the counter needs no decode of its own.

Parameters:
- T_MAX, 5, index of the last T-state. Legal range 4..7. The step counter wraps from T_MAX to T0.
- OPCODE_W, 4, opcode field width taken from the IR upper nibble.

Ports:
- clock  in  1  system clock; all state changes on the rising edge
- clear  in  1  synchronous active-high reset
- run  in  1  1 = advance; 0 = freeze step counter and gate all strobes to 0
- opcode  in  OPCODE_W  IR upper nibble, valid from T2 onward
- carry_flag  in  1  registered ALU carry
- zero_flag  in  1  registered ALU zero
- t_state  out  3  current step index
- pc_out, pc_inc, jmp  out  1 each  program counter controls
- mar_in, ram_in, ram_out, ir_in, ir_out  out  1 each  memory and IR strobes
- a_in, a_out, b_in, alu_out, sub, flags_in, out_in  out  1 each  datapath strobes
- halted  out  1  sticky halt indicator

Behaviour:
- State: t (3 bits), halted_r.
- On clear (synchronous): t=0, halted_r=0. While clear=1, all strobes are combinationally forced to 0, t_state=0 and halted=0.
- Strobes are a combinational decode of (t, opcode, flags), gated by run & ~halted_r & ~clear. At most one bus driver is active per step: pc_out, ram_out, ir_out, a_out, alu_out.
- Fetch, all opcodes:
  - T0: pc_out, mar_in
  - T1: ram_out, ir_in, pc_inc
- Execute, T2.. (any step not listed drives nothing):
  - 0000 NOP: nothing
  - 0001 LDA: T2 ir_out+mar_in; T3 ram_out+a_in
  - 0010 ADD: T2 ir_out+mar_in; T3 ram_out+b_in; T4 alu_out+a_in+flags_in
  - 0011 SUB: as ADD, with sub also asserted at T4
  - 0100 STA: T2 ir_out+mar_in; T3 a_out+ram_in
  - 0101 LDI: T2 ir_out+a_in
  - 0110 JMP: T2 ir_out+jmp
  - 0111 JC: T2 ir_out+jmp only if carry_flag=1; else nothing
  - 1000 JZ: T2 ir_out+jmp only if zero_flag=1; else nothing
  - 1110 OUT: T2 a_out+out_in
  - 1111 HLT: at T2, halted_r<=1 on the clock edge. No other strobes are asserted.
  - Undefined opcodes (1001..1101) behave as NOP.
- Step counter: if run & ~halted_r, t <= (t==T_MAX) ? 0 : t+1 (subject to the optional feature). If run=0, t holds; resuming continues the same instruction at the same step.
- Halt: halted_r is set only by HLT and cleared only by clear. While set, t holds its value and all strobes are 0. The halted output equals halted_r.
- Flags are sampled combinationally in T2 of JC/JZ. No registered copy is kept.
- Simultaneous clear and HLT at T2: clear wins.

Optional Feature:
- Macro: CTRL_EARLY_FETCH_EN.
- Defined: after an instruction's last active step, t <= 0 instead of running to T_MAX.
  - Last step is T2 for NOP, LDI, JMP, JC, JZ and OUT; T3 for LDA and STA; T4 for ADD and SUB.
  - Undefined opcodes behave as NOP, i.e. return at T2.
  - A not-taken JC/JZ also returns at T2.
- Undefined: every instruction runs T0..T_MAX. Steps with no entry drive no strobes.

Test Plan:
- Reset: clear=1 for 2 cycles with run=1 -> t_state=0, all strobes 0, halted=0. First cycle after release: pc_out=1, mar_in=1.
- LDA fetch/execute, opcode=0001, T_MAX=5, feature off:
  - T0 pc_out+mar_in; T1 ram_out+ir_in+pc_inc; T2 ir_out+mar_in; T3 ram_out+a_in; T4, T5 all 0
  - Then t_state returns to 0; total 6 cycles.
- SUB, opcode=0011 -> T4 asserts alu_out, a_in, flags_in and sub together. sub=0 in all other steps and for ADD.
- JC: carry_flag=1 at T2 -> jmp=1, ir_out=1. carry_flag=0 -> jmp=0, ir_out=0. Same check for JZ with zero_flag.
- run=0 asserted at T3 of ADD for 3 cycles -> t_state stays 3 and all strobes 0. On run=1, T3 strobes ram_out+b_in reappear, then T4 follows.
- HLT, opcode=1111:
  - halted=1 from the cycle after T2; t_state frozen; strobes 0 for 10+ cycles.
  - clear -> halted=0, t_state=0.
  - With CTRL_EARLY_FETCH_EN: LDI completes in 3 cycles and ADD in 5.
